vga_sync_decoder: RTL and testbench

Receive-side counterpart of the VGA timing controller. It samples the `hsync`/`vsync`/`rgb` stream at the pixel tick and recovers pixel coordinates, frame boundaries and a lock indication. It checks every sync sample against the configured 640x480 timing and counts violations. An optional probe captures the colour at one coordinate per frame. The block is used for on-board loopback self-check of the pixel generator, and its 16-bit counters feed the sequence-debug display.

---
 rtl/vga_sync_decoder.sv | 201 ++++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing decoder: recovers pixel coordinates, frame pulses and lock
// from a sampled hsync/vsync/rgb stream. Optional colour probe under VGA_DEC_PROBE_EN.
module vga_sync_decoder #(
    parameter int H_VIS    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_VIS    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b1,
    parameter int PIPE_DLY = 1
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        p_tick,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [11:0] rgb,
    input  logic [9:0]  probe_x,
    input  logic [9:0]  probe_y,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        video_on,
    output logic        locked,
    output logic        frame_start,
    output logic [15:0] err_cnt,
    output logic [15:0] frame_cnt,
    output logic [11:0] probe_rgb,
    output logic        probe_valid
);

    localparam logic [9:0] H_LAST = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HS_BEG = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END = 10'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic [9:0] H_VIS_C = 10'(H_VIS);
    localparam logic [9:0] V_VIS_C = 10'(V_VIS);

    typedef enum logic [1:0] {SEARCH, HALIGN, LOCKED} state_e;

    typedef struct packed {
        logic       vld;
        logic       vis;
        logic [9:0] h;
        logic [9:0] v;
    } coord_t;

    state_e      state_q, state_d;
    logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic        hs_prev_q, vs_prev_q;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        frame_start_q, frame_start_d;
    coord_t      pipe_q [0:PIPE_DLY];
    coord_t      pipe_d [0:PIPE_DLY];
    coord_t      cur, out_d;

    logic       hs_act, vs_act, hs_rise, vs_rise;
    logic       h_wrap, hs_exp, vs_exp, hs_bad, vs_bad, err_evt;
    logic [9:0] h_nxt, v_nxt;

    assign hs_act  = (hsync == SYNC_POL);
    assign vs_act  = (vsync == SYNC_POL);
    assign hs_rise = hs_act & ~hs_prev_q;
    assign vs_rise = vs_act & ~vs_prev_q;

    // Position this tick's sample occupies if the stream is on time.
    assign h_wrap = (h_cnt_q == H_LAST);
    assign h_nxt  = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
    assign v_nxt  = !h_wrap ? v_cnt_q : ((v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1);
    assign hs_exp = (h_nxt >= HS_BEG) && (h_nxt <= HS_END);
    assign vs_exp = (v_nxt >= VS_BEG) && (v_nxt <= VS_END);
    assign hs_bad = (hs_act != hs_exp);
    assign vs_bad = (vs_act != vs_exp);

    always_comb begin
        state_d = state_q;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        err_evt = 1'b0;
        if (p_tick) begin
            case (state_q)
                SEARCH: begin
                    if (hs_rise) begin
                        h_cnt_d = HS_BEG;
                        state_d = HALIGN;
                    end
                end
                HALIGN: begin
                    h_cnt_d = h_nxt;
                    v_cnt_d = v_nxt;
                    if (hs_bad) begin
                        err_evt = 1'b1;
                        state_d = SEARCH;
                    end else if (vs_rise) begin
                        v_cnt_d = VS_BEG;
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    h_cnt_d = h_nxt;
                    v_cnt_d = v_nxt;
                    if (hs_bad || vs_bad) begin
                        err_evt = 1'b1;
                        state_d = SEARCH;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    assign err_cnt_d = (err_evt && (err_cnt_q != 16'hFFFF)) ? err_cnt_q + 16'd1 : err_cnt_q;

    // Coordinate delay line keeps x/y aligned with the lagging rgb; emptied whenever unlocked.
    always_comb begin
        cur.vld = 1'b1;
        cur.vis = (h_cnt_d < H_VIS_C) && (v_cnt_d < V_VIS_C);
        cur.h   = h_cnt_d;
        cur.v   = v_cnt_d;
        for (int k = 0; k <= PIPE_DLY; k++) pipe_d[k] = pipe_q[k];
        if (state_d != LOCKED) begin
            for (int k = 0; k <= PIPE_DLY; k++) pipe_d[k] = '0;
        end else if (p_tick) begin
            pipe_d[0] = cur;
            for (int k = 1; k <= PIPE_DLY; k++) pipe_d[k] = pipe_q[k-1];
        end
    end

    assign out_d         = pipe_d[PIPE_DLY];
    assign frame_start_d = p_tick && (state_d == LOCKED) && out_d.vld &&
                           (out_d.h == 10'd0) && (out_d.v == 10'd0);
    assign frame_cnt_d   = frame_start_d ? frame_cnt_q + 16'd1 : frame_cnt_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= SEARCH;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            hs_prev_q     <= 1'b0;
            vs_prev_q     <= 1'b0;
            err_cnt_q     <= '0;
            frame_cnt_q   <= '0;
            frame_start_q <= 1'b0;
            for (int k = 0; k <= PIPE_DLY; k++) pipe_q[k] <= '0;
        end else begin
            state_q       <= state_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            err_cnt_q     <= err_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            frame_start_q <= frame_start_d;
            for (int k = 0; k <= PIPE_DLY; k++) pipe_q[k] <= pipe_d[k];
            if (p_tick) begin
                hs_prev_q <= hs_act;
                vs_prev_q <= vs_act;
            end
        end
    end

    assign locked      = (state_q == LOCKED);
    assign x           = pipe_q[PIPE_DLY].h;
    assign y           = pipe_q[PIPE_DLY].v;
    assign video_on    = pipe_q[PIPE_DLY].vld & pipe_q[PIPE_DLY].vis;
    assign err_cnt     = err_cnt_q;
    assign frame_cnt   = frame_cnt_q;
    assign frame_start = frame_start_q;

`ifdef VGA_DEC_PROBE_EN
    logic [11:0] probe_rgb_q, probe_rgb_d;
    logic        probe_valid_q, probe_hit;

    // Only visible pixels can match, so off-screen probe coordinates never fire.
    assign probe_hit   = p_tick && (state_d == LOCKED) && out_d.vld && out_d.vis &&
                         (out_d.h == probe_x) && (out_d.v == probe_y);
    assign probe_rgb_d = probe_hit ? rgb : probe_rgb_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            probe_rgb_q   <= '0;
            probe_valid_q <= 1'b0;
        end else begin
            probe_rgb_q   <= probe_rgb_d;
            probe_valid_q <= probe_hit;
        end
    end

    assign probe_rgb   = probe_rgb_q;
    assign probe_valid = probe_valid_q;
`else
    logic unused_probe;
    assign unused_probe = ^{rgb, probe_x, probe_y};
    assign probe_rgb    = '0;
    assign probe_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Scoreboard bench for vga_sync_decoder on a shrunken raster (24x14 totals) so
// several whole frames fit in a short run; frame_start/probe events are queued and matched.
module tb_vga_sync_decoder;
    localparam int H_VIS = 16, H_FP = 2, H_SYNC = 4, H_BP = 2;
    localparam int V_VIS = 8,  V_FP = 2, V_SYNC = 2, V_BP = 2;
    localparam bit SYNC_POL = 1'b1;
    localparam int PIPE_DLY = 1;
    localparam int H_TOT = 24, V_TOT = 14, F = 336;
    localparam int HS_BEG = 18, HS_END = 21, VS_BEG = 10, VS_END = 11;
    localparam int PX = 10, PY = 5;

    logic        sys_clk, sys_rst_n, p_tick, hsync, vsync;
    logic [11:0] rgb;
    logic [9:0]  probe_x, probe_y, x, y;
    logic        video_on, locked, frame_start, probe_valid;
    logic [15:0] err_cnt, frame_cnt;
    logic [11:0] probe_rgb;

    vga_sync_decoder #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .SYNC_POL(SYNC_POL), .PIPE_DLY(PIPE_DLY)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .p_tick(p_tick),
        .hsync(hsync), .vsync(vsync), .rgb(rgb),
        .probe_x(probe_x), .probe_y(probe_y),
        .x(x), .y(y), .video_on(video_on), .locked(locked),
        .frame_start(frame_start), .err_cnt(err_cnt), .frame_cnt(frame_cnt),
        .probe_rgb(probe_rgb), .probe_valid(probe_valid)
    );

    typedef struct {
        int unsigned cyc;
        logic [15:0] val;
    } ev_t;

    ev_t fs_q[$];
    ev_t pr_q[$];

    int unsigned cyc = 0;
    int n_checks = 0, n_fail = 0;
    int sh, sv, lk, lock_bad, coord_bad;
    bit exp_lock, hs_seen, prev_hs, prev_vs;
    logic [15:0] exp_err, exp_fcnt;
    logic [9:0] exp_x, exp_y;

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // Monitor: match every output pulse against the queued expectation.
    always @(negedge sys_clk) begin
        ev_t e;
        while (fs_q.size() > 0 && fs_q[0].cyc < cyc) begin
            chk("frame_start_missing", 32'(fs_q[0].cyc), 32'(cyc));
            void'(fs_q.pop_front());
        end
        while (pr_q.size() > 0 && pr_q[0].cyc < cyc) begin
            chk("probe_valid_missing", 32'(pr_q[0].cyc), 32'(cyc));
            void'(pr_q.pop_front());
        end
        if (frame_start) begin
            if (fs_q.size() == 0) chk("frame_start_unexpected", 32'(frame_start), 32'd0);
            else begin
                e = fs_q.pop_front();
                chk("frame_start_cycle", cyc, e.cyc);
                chk("frame_cnt_at_start", 32'(frame_cnt), 32'(e.val));
            end
        end
        if (probe_valid) begin
            if (pr_q.size() == 0) chk("probe_valid_unexpected", 32'(probe_valid), 32'd0);
            else begin
                e = pr_q.pop_front();
                chk("probe_cycle", cyc, e.cyc);
                chk("probe_rgb", 32'(probe_rgb), 32'(e.val));
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // One pixel tick of the reference stream, then three idle clocks.
    task automatic gen_tick(input bit force_hs, input bit err_tick);
        int lin, d, dx, dy;
        bit hs_a, vs_a, hs_e, vs_e, vld, vis;
        lin  = sv * H_TOT + sh;
        d    = (lin + F - PIPE_DLY) % F;
        dx   = d % H_TOT;
        dy   = d / H_TOT;
        hs_a = force_hs || (sh >= HS_BEG && sh <= HS_END);
        vs_a = (sv >= VS_BEG && sv <= VS_END);
        hsync  = hs_a ? SYNC_POL : !SYNC_POL;
        vsync  = vs_a ? SYNC_POL : !SYNC_POL;
        rgb    = 12'(dx);
        p_tick = 1'b1;
        @(posedge sys_clk); #1;
        p_tick = 1'b0;
        hs_e = hs_a && !prev_hs;
        vs_e = vs_a && !prev_vs;
        prev_hs = hs_a;
        prev_vs = vs_a;
        if (err_tick) begin
            exp_lock = 1'b0; hs_seen = 1'b0; lk = 0;
            if (exp_err != 16'hFFFF) exp_err++;
        end else if (!exp_lock) begin
            if (vs_e && hs_seen) begin exp_lock = 1'b1; lk = 0; end
            else if (hs_e) hs_seen = 1'b1;
        end
        if (exp_lock) lk++;
        vld   = exp_lock && (lk >= PIPE_DLY + 1);
        vis   = vld && dx < H_VIS && dy < V_VIS;
        exp_x = vld ? 10'(dx) : 10'd0;
        exp_y = vld ? 10'(dy) : 10'd0;
        if (locked !== exp_lock) lock_bad++;
        if (x !== exp_x || y !== exp_y || video_on !== vis) coord_bad++;
        if (vld && dx == 0 && dy == 0) begin
            exp_fcnt++;
            fs_q.push_back('{cyc: cyc, val: exp_fcnt});
        end
`ifdef VGA_DEC_PROBE_EN
        if (vis && dx == PX && dy == PY) pr_q.push_back('{cyc: cyc, val: 16'(dx)});
`endif
        sh++;
        if (sh == H_TOT) begin sh = 0; sv = (sv + 1) % V_TOT; end
        repeat (3) @(posedge sys_clk);
        #1;
    endtask

    task automatic gen_until(input int tx, input int ty);
        int n = 0;
        while (!(sh == tx && sv == ty)) begin
            if (n > F) begin
                n_checks++; n_fail++;
                $display("FAIL gen_until_timeout: got %0d,%0d expected %0d,%0d", sh, sv, tx, ty);
                return;
            end
            gen_tick(1'b0, 1'b0);
            n++;
        end
    endtask

    task automatic model_reset();
        exp_lock = 0; hs_seen = 0; prev_hs = 0; prev_vs = 0; lk = 0;
        exp_err = '0; exp_fcnt = '0; exp_x = '0; exp_y = '0;
    endtask

    initial begin
        sys_rst_n = 1'b0; p_tick = 1'b0; hsync = 1'b0; vsync = 1'b0; rgb = '0;
        probe_x = 10'(PX); probe_y = 10'(PY);
        sh = 0; sv = 0; lock_bad = 0; coord_bad = 0;
        model_reset();
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_x", 32'(x), 0);                 chk("rst_y", 32'(y), 0);
        chk("rst_video_on", 32'(video_on), 0);   chk("rst_locked", 32'(locked), 0);
        chk("rst_frame_start", 32'(frame_start), 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);     chk("rst_frame_cnt", 32'(frame_cnt), 0);
        chk("rst_probe_rgb", 32'(probe_rgb), 0); chk("rst_probe_valid", 32'(probe_valid), 0);
        sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;

        // Ideal stream, three frames from (0,0).
        gen_until(0, VS_BEG);
        chk("pre_vsync_unlocked", 32'(locked), 0);
        gen_tick(0, 0);
        chk("lock_at_first_vsync", 32'(locked), 1);
        gen_until(0, 0);
        repeat (2 * F) gen_tick(0, 0);
        chk("frame_cnt_after_3_frames", 32'(frame_cnt), 2);
        chk("err_cnt_ideal", 32'(err_cnt), 0);
        chk("lock_track_ideal", lock_bad, 0);
        chk("coord_track_ideal", coord_bad, 0);

        // hsync one tick early.
        gen_until(HS_BEG - 1, 3);
        gen_tick(1, 1);
        chk("early_hs_err_cnt", 32'(err_cnt), 1);
        chk("early_hs_unlock", 32'(locked), 0);
        gen_until(0, VS_BEG);
        chk("no_relock_before_vsync", 32'(locked), 0);
        gen_tick(0, 0);
        chk("relock_at_vsync", 32'(locked), 1);
        chk("err_cnt_after_relock", 32'(err_cnt), 1);

        // hsync stuck asserted for two frames.
        gen_until(0, 0);
        for (int i = 0; i < 2 * F; i++) gen_tick(1, i == 0);
        chk("stuck_err_once", 32'(err_cnt), 2);
        chk("stuck_locked_low", 32'(locked), 0);
        gen_until(0, VS_BEG);
        gen_tick(0, 0);
        chk("relock_after_stuck", 32'(locked), 1);

        // Asynchronous reset mid-frame.
        gen_until(5, 7);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("midrst_locked", 32'(locked), 0);   chk("midrst_err_cnt", 32'(err_cnt), 0);
        chk("midrst_frame_cnt", 32'(frame_cnt), 0);
        chk("midrst_x", 32'(x), 0);             chk("midrst_y", 32'(y), 0);
        chk("midrst_video_on", 32'(video_on), 0);
        model_reset();
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        gen_until(0, VS_BEG);
        chk("midrst_no_early_lock", 32'(locked), 0);
        gen_tick(0, 0);
        chk("midrst_relock", 32'(locked), 1);

        // p_tick held low with noisy inputs.
        gen_until(8, 2);
        repeat (1000) begin
            hsync = 1'($urandom_range(0, 1));
            vsync = 1'($urandom_range(0, 1));
            rgb   = 12'($urandom);
            @(posedge sys_clk);
        end
        #1;
        chk("hold_x", 32'(x), 32'(exp_x));       chk("hold_y", 32'(y), 32'(exp_y));
        chk("hold_locked", 32'(locked), 1);
        chk("hold_err_cnt", 32'(err_cnt), 32'(exp_err));
        chk("hold_frame_cnt", 32'(frame_cnt), 32'(exp_fcnt));
        gen_until(0, 0);
        repeat (F) gen_tick(0, 0);
        chk("resume_locked", 32'(locked), 1);
        chk("resume_err_cnt", 32'(err_cnt), 0);
        chk("frame_cnt_final", 32'(frame_cnt), 32'(exp_fcnt));
        chk("lock_track_all", lock_bad, 0);
        chk("coord_track_all", coord_bad, 0);
`ifdef VGA_DEC_PROBE_EN
        chk("probe_rgb_final", 32'(probe_rgb), 32'h064 - 32'h05A);
`else
        chk("probe_rgb_disabled", 32'(probe_rgb), 0);
        chk("probe_valid_disabled", 32'(probe_valid), 0);
`endif
        repeat (4) @(posedge sys_clk);
        #1;
        chk("frame_start_queue_empty", fs_q.size(), 0);
        chk("probe_queue_empty", pr_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
